// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state
// encodings, counter width and the jump-shadow counter width.
package pipeline_ctrl_pkg;

   // Controller state encodings, shared with anything that decodes the state.
   localparam logic [1:0] PCTRL_ST_IDLE = 2'd0;
   localparam logic [1:0] PCTRL_ST_RUN  = 2'd1;
   localparam logic [1:0] PCTRL_ST_MEMW = 2'd2;
   localparam logic [1:0] PCTRL_ST_HALT = 2'd3;

   // Default width of the performance counters.
   localparam int PCTRL_CNT_W = 32;

   // The jump shadow never exceeds the largest legal IMEM_LAT (6).
   localparam int SHADOW_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = PCTRL_ST_IDLE,
      ST_RUN  = PCTRL_ST_RUN,
      ST_MEMW = PCTRL_ST_MEMW,
      ST_HALT = PCTRL_ST_HALT
   } pctrl_state_t;

   // Next value of the jump-shadow counter in a cycle the pipeline advances:
   // a taken jump reloads it, otherwise it drains towards zero.
   function automatic logic [SHADOW_W-1:0] shadow_advance(
      input logic                jump,
      input logic [SHADOW_W-1:0] cur,
      input logic [SHADOW_W-1:0] reload
   );
      if (jump)
         return reload;
      else if (cur != '0)
         return cur - SHADOW_W'(1);
      else
         return cur;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: flags when the instruction in a producing stage is a
// load whose destination is read by the instruction in ID. Purely
// combinational so it can be reused by the MM-stage forwarding check.
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  is_load,
   input  logic                  reg_wr,
   input  logic [REG_ADDR_W-1:0] reg_addr_rd,
   input  logic                  uses_r1,
   input  logic                  uses_r2,
   input  logic [REG_ADDR_W-1:0] reg_addr_r1,
   input  logic [REG_ADDR_W-1:0] reg_addr_r2,
   output logic                  hit
);

   logic producer_live;
   logic match_r1;
   logic match_r2;

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   always_comb begin
      producer_live = is_load && reg_wr && (reg_addr_rd != '0);
      match_r1      = uses_r1 && (reg_addr_rd == reg_addr_r1);
      match_r2      = uses_r2 && (reg_addr_rd == reg_addr_r2);
      hit           = producer_live && (match_r1 || match_r2);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline. Produces the
// global enable, front/back-end stalls, front-end kill and EX bubble, and
// keeps cycle / stall performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int IMEM_LAT   = 1,
   parameter int CNT_W      = PCTRL_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  ID_uses_r1,
   input  logic                  ID_uses_r2,
   input  logic [REG_ADDR_W-1:0] ID_reg_addr_r1,
   input  logic [REG_ADDR_W-1:0] ID_reg_addr_r2,
   input  logic                  EX_is_load,
   input  logic                  EX_reg_wr,
   input  logic [REG_ADDR_W-1:0] EX_reg_addr_rd,
   input  logic                  EX_jump,
   input  logic                  MM_req,
   input  logic                  MM_ack,
   output logic                  en,
   output logic                  stall_fe,
   output logic                  stall_be,
   output logic                  kill_fe,
   output logic                  bubble_ex,
   output logic                  halted,
   output logic [CNT_W-1:0]      cyc_cnt,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [SHADOW_W-1:0] SHADOW_RELOAD = SHADOW_W'(IMEM_LAT);

   pctrl_state_t          state_q;
   pctrl_state_t          state_d;
   logic [SHADOW_W-1:0]   shadow_q;
   logic [SHADOW_W-1:0]   shadow_d;
   logic                  bubble_q;
   logic                  lu_hit;
   logic                  mem_stall;
   logic                  shadow_live;
   logic [CNT_W-1:0]      cyc_cnt_q;
   logic [CNT_W-1:0]      stall_cnt_q;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .is_load     (EX_is_load),
      .reg_wr      (EX_reg_wr),
      .reg_addr_rd (EX_reg_addr_rd),
      .uses_r1     (ID_uses_r1),
      .uses_r2     (ID_uses_r2),
      .reg_addr_r1 (ID_reg_addr_r1),
      .reg_addr_r2 (ID_reg_addr_r2),
      .hit         (lu_hit)
   );

   assign mem_stall   = MM_req && !MM_ack;
   assign shadow_live = (shadow_q != '0);

   // State register, jump-shadow counter and last-cycle-bubble flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         bubble_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples the values from before this edge.
         state_q  <= state_d;
         shadow_q <= shadow_d;
         bubble_q <= bubble_ex;
      end
   end

   // Next-state and output decode from the current state and hazard inputs.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case below can leave a latch behind.
      state_d   = state_q;
      shadow_d  = shadow_q;
      en        = 1'b0;
      stall_fe  = 1'b0;
      stall_be  = 1'b0;
      kill_fe   = 1'b0;
      bubble_ex = 1'b0;
      halted    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            kill_fe = 1'b1;
            if (start)
               state_d = ST_RUN;
         end

         ST_RUN: begin
            en = 1'b1;
            if (mem_stall) begin
               // EX and MM are frozen: the jump in EX is seen again later and
               // the shadow keeps its count.
               stall_fe = 1'b1;
               stall_be = 1'b1;
               kill_fe  = shadow_live;
               state_d  = ST_MEMW;
            end else begin
               kill_fe  = EX_jump || shadow_live;
               shadow_d = shadow_advance(EX_jump, shadow_q, SHADOW_RELOAD);
               // The ID instruction is wrong-path while killing; after one
               // bubble the load has moved on, so never stall twice in a row.
               if (lu_hit && !kill_fe && !bubble_q) begin
                  stall_fe  = 1'b1;
                  bubble_ex = 1'b1;
               end
               if (halt_req && !kill_fe && !stall_fe)
                  state_d = ST_HALT;
            end
         end

         ST_MEMW: begin
            en = 1'b1;
            if (!MM_ack) begin
               stall_fe = 1'b1;
               stall_be = 1'b1;
               kill_fe  = shadow_live;
            end else begin
               // Bus completes: the pipeline advances this cycle, so a jump
               // waiting in EX takes effect now.
               kill_fe  = EX_jump || shadow_live;
               shadow_d = shadow_advance(EX_jump, shadow_q, SHADOW_RELOAD);
               state_d  = ST_RUN;
            end
         end

         ST_HALT: begin
            halted = 1'b1;
            if (start)
               state_d = ST_RUN;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Performance counters: free-running, wrap on overflow, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (en)
            cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
         if (stall_fe)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign cyc_cnt   = cyc_cnt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a driver issues directed then random
// cycles and pushes the reference model's expected outputs into a queue; a
// monitor pops and compares them on the falling edge.
module tb_pipeline_ctrl;

   localparam int REG_ADDR_W = 5;
   localparam int IMEM_LAT   = 1;
   localparam int CNT_W      = 32;
   localparam int N_RANDOM   = 3000;

   logic                  clk;
   logic                  rst_n;
   logic                  start;
   logic                  halt_req;
   logic                  ID_uses_r1;
   logic                  ID_uses_r2;
   logic [REG_ADDR_W-1:0] ID_reg_addr_r1;
   logic [REG_ADDR_W-1:0] ID_reg_addr_r2;
   logic                  EX_is_load;
   logic                  EX_reg_wr;
   logic [REG_ADDR_W-1:0] EX_reg_addr_rd;
   logic                  EX_jump;
   logic                  MM_req;
   logic                  MM_ack;
   logic                  en;
   logic                  stall_fe;
   logic                  stall_be;
   logic                  kill_fe;
   logic                  bubble_ex;
   logic                  halted;
   logic [CNT_W-1:0]      cyc_cnt;
   logic [CNT_W-1:0]      stall_cnt;

   pipeline_ctrl #(
      .REG_ADDR_W (REG_ADDR_W),
      .IMEM_LAT   (IMEM_LAT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt_req       (halt_req),
      .ID_uses_r1     (ID_uses_r1),
      .ID_uses_r2     (ID_uses_r2),
      .ID_reg_addr_r1 (ID_reg_addr_r1),
      .ID_reg_addr_r2 (ID_reg_addr_r2),
      .EX_is_load     (EX_is_load),
      .EX_reg_wr      (EX_reg_wr),
      .EX_reg_addr_rd (EX_reg_addr_rd),
      .EX_jump        (EX_jump),
      .MM_req         (MM_req),
      .MM_ack         (MM_ack),
      .en             (en),
      .stall_fe       (stall_fe),
      .stall_be       (stall_be),
      .kill_fe        (kill_fe),
      .bubble_ex      (bubble_ex),
      .halted         (halted),
      .cyc_cnt        (cyc_cnt),
      .stall_cnt      (stall_cnt)
   );

   typedef struct packed {
      logic                  start;
      logic                  halt_req;
      logic                  uses_r1;
      logic                  uses_r2;
      logic [REG_ADDR_W-1:0] r1;
      logic [REG_ADDR_W-1:0] r2;
      logic                  is_load;
      logic                  reg_wr;
      logic [REG_ADDR_W-1:0] rd;
      logic                  jump;
      logic                  req;
      logic                  ack;
   } stim_t;

   typedef struct packed {
      logic [5:0]       ctrl;   // {en, stall_fe, stall_be, kill_fe, bubble_ex, halted}
      logic [CNT_W-1:0] cyc;
      logic [CNT_W-1:0] stl;
   } exp_t;

   typedef enum int {M_IDLE, M_RUN, M_WAIT, M_HALT} mode_t;

   int     tests = 0;
   int     fails = 0;
   exp_t   sb_q[$];

   // Reference model state: what the core is doing, how many wrong-path
   // fetches remain after a jump, whether last cycle injected a bubble.
   mode_t            m_mode;
   int               m_shadow;
   bit               m_prev_bub;
   logic [CNT_W-1:0] m_cyc;
   logic [CNT_W-1:0] m_stl;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [CNT_W-1:0] act,
                        input logic [CNT_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode     = M_IDLE;
      m_shadow   = 0;
      m_prev_bub = 1'b0;
      m_cyc      = '0;
      m_stl      = '0;
   endtask

   // One cycle of the reference model: returns this cycle's outputs and
   // advances the model to the next cycle.
   task automatic model_cycle(input stim_t s, output exp_t e);
      bit    o_en, o_sfe, o_sbe, o_kill, o_bub, o_halt;
      bit    match, mstall, advance;
      mode_t nxt;
      o_en = 0; o_sfe = 0; o_sbe = 0; o_kill = 0; o_bub = 0; o_halt = 0;
      advance = 0;
      nxt     = m_mode;
      match   = s.is_load && s.reg_wr && (s.rd != 0) &&
                ((s.uses_r1 && s.rd == s.r1) || (s.uses_r2 && s.rd == s.r2));
      mstall  = s.req && !s.ack;
      case (m_mode)
         M_IDLE: begin
            o_kill = 1;
            if (s.start) nxt = M_RUN;
         end
         M_RUN: begin
            o_en = 1;
            if (mstall) begin
               o_sfe = 1; o_sbe = 1;
               o_kill = (m_shadow > 0);
               nxt = M_WAIT;
            end else begin
               o_kill  = s.jump || (m_shadow > 0);
               advance = 1;
               if (match && !o_kill && !m_prev_bub) begin
                  o_sfe = 1; o_bub = 1;
               end
               if (s.halt_req && !o_kill && !o_sfe) nxt = M_HALT;
            end
         end
         M_WAIT: begin
            o_en = 1;
            if (!s.ack) begin
               o_sfe = 1; o_sbe = 1;
               o_kill = (m_shadow > 0);
            end else begin
               o_kill  = s.jump || (m_shadow > 0);
               advance = 1;
               nxt     = M_RUN;
            end
         end
         default: begin
            o_halt = 1;
            if (s.start) nxt = M_RUN;
         end
      endcase
      e.ctrl = {o_en, o_sfe, o_sbe, o_kill, o_bub, o_halt};
      e.cyc  = m_cyc;
      e.stl  = m_stl;
      if (advance) begin
         if (s.jump)            m_shadow = IMEM_LAT;
         else if (m_shadow > 0) m_shadow = m_shadow - 1;
      end
      if (o_en)  m_cyc = m_cyc + 1;
      if (o_sfe) m_stl = m_stl + 1;
      m_prev_bub = o_bub;
      m_mode     = nxt;
   endtask

   task automatic apply(input stim_t s);
      start          = s.start;
      halt_req       = s.halt_req;
      ID_uses_r1     = s.uses_r1;
      ID_uses_r2     = s.uses_r2;
      ID_reg_addr_r1 = s.r1;
      ID_reg_addr_r2 = s.r2;
      EX_is_load     = s.is_load;
      EX_reg_wr      = s.reg_wr;
      EX_reg_addr_rd = s.rd;
      EX_jump        = s.jump;
      MM_req         = s.req;
      MM_ack         = s.ack;
   endtask

   // Drive one cycle's inputs just after the rising edge and queue the
   // expected response for the monitor.
   task automatic drive(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      apply(s);
      model_cycle(s, e);
      sb_q.push_back(e);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.start    = ($urandom_range(15) == 0);
      s.halt_req = ($urandom_range(9) == 0);
      s.uses_r1  = $urandom_range(1);
      s.uses_r2  = $urandom_range(1);
      s.r1       = REG_ADDR_W'($urandom_range(3));
      s.r2       = REG_ADDR_W'($urandom_range(3));
      s.is_load  = $urandom_range(1);
      s.reg_wr   = ($urandom_range(3) != 0);
      s.rd       = REG_ADDR_W'($urandom_range(3));
      s.jump     = ($urandom_range(5) == 0);
      s.req      = ($urandom_range(3) == 0);
      s.ack      = $urandom_range(1);
      return s;
   endfunction

   function automatic stim_t quiet();
      return '0;
   endfunction

   function automatic stim_t lu(input logic [REG_ADDR_W-1:0] rd, input logic use1);
      stim_t s = '0;
      s.is_load = 1; s.reg_wr = 1; s.rd = rd; s.r1 = 5'd5; s.uses_r1 = use1;
      return s;
   endfunction

   // Monitor: compare DUT outputs with the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("ctrl{en,sfe,sbe,kill,bub,halted}",
                  CNT_W'({en, stall_fe, stall_be, kill_fe, bubble_ex, halted}),
                  CNT_W'(e.ctrl));
            check("cyc_cnt", cyc_cnt, e.cyc);
            check("stall_cnt", stall_cnt, e.stl);
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      rst_n = 1'b0;
      apply(quiet());
      model_reset();
      #12;
      check("reset en", CNT_W'(en), '0);
      check("reset kill_fe", CNT_W'(kill_fe), CNT_W'(1));
      check("reset cyc_cnt", cyc_cnt, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed: idle, start pulse, three plain RUN cycles.
      drive(quiet());
      s = quiet(); s.start = 1; drive(s);
      repeat (3) drive(quiet());
      // Load-use on rs1, then the rd=0 and uses_r1=0 variants.
      drive(lu(5'd5, 1'b1)); drive(quiet());
      drive(lu(5'd0, 1'b1)); drive(lu(5'd5, 1'b0)); drive(quiet());
      // Jump followed by a load-use match in the shadow.
      s = quiet(); s.jump = 1; drive(s);
      drive(lu(5'd5, 1'b1)); drive(quiet());
      // Three wait cycles with a jump held in EX, then the ack.
      s = quiet(); s.req = 1; s.jump = 1;
      repeat (3) drive(s);
      s.ack = 1; drive(s);
      repeat (2) drive(quiet());
      // Halt, idle while halted, then restart.
      s = quiet(); s.halt_req = 1; drive(s);
      repeat (3) drive(quiet());
      s = quiet(); s.start = 1; drive(s);
      drive(quiet());

      // Randomized traffic.
      for (int i = 0; i < N_RANDOM; i++)
         drive(rand_stim());

      // Get into MEM_WAIT and drop reset between clock edges.
      s = quiet(); s.start = 1; s.ack = 1; drive(s);
      s = quiet(); s.req = 1; drive(s);
      drive(s);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async reset en", CNT_W'(en), '0);
      check("async reset stalls", CNT_W'({stall_fe, stall_be}), '0);
      check("async reset kill_fe", CNT_W'(kill_fe), CNT_W'(1));
      check("async reset cyc_cnt", cyc_cnt, '0);
      check("async reset stall_cnt", stall_cnt, '0);
      check("scoreboard drained", CNT_W'(sb_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for one core's 5-stage pipeline (IF, ID, EX, MM, WB). It generates the global enable, the stall and flush controls consumed by the IF/ID/EX/MM pipeline registers, and the bubble-injection signal for EX. It resolves three hazards: load-use, taken jump/branch from EX, and data-memory wait states from the shared bus. It also keeps cycle and stall performance counters for multicore profiling.

Parameters:
REG_ADDR_W, 5, register address width (matches `REG_ADDR_W).
IMEM_LAT, 1, instruction-memory latency in cycles; sets the jump shadow length; legal range 0..6.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  core-start pulse from the multicore boot logic
halt_req  in  1  halt instruction decoded in ID
ID_uses_r1  in  1  ID instruction reads rs1
ID_uses_r2  in  1  ID instruction reads rs2
ID_reg_addr_r1  in  REG_ADDR_W  rs1 of the ID instruction
ID_reg_addr_r2  in  REG_ADDR_W  rs2 of the ID instruction
EX_is_load  in  1  EX instruction is a load
EX_reg_wr  in  1  EX instruction writes rd
EX_reg_addr_rd  in  REG_ADDR_W  rd of the EX instruction
EX_jump  in  1  taken jump/branch from EX (already gated by the EX flush input)
MM_req  in  1  MM stage issues a data access
MM_ack  in  1  data bus grant/complete
en  out  1  global pipeline enable
stall_fe  out  1  hold the IF and ID registers
stall_be  out  1  hold the EX and MM registers
kill_fe  out  1  mark IF/ID contents as flushed
bubble_ex  out  1  force the flush input of the EX stage
halted  out  1  core is in HALTED
cyc_cnt  out  CNT_W  count of cycles with en=1
stall_cnt  out  CNT_W  count of cycles with stall_fe=1

Behaviour:
- Reset: rst_n low takes effect immediately (asynchronous). State goes to IDLE, the shadow counter to 0, both perf counters to 0. While in IDLE: en=0, kill_fe=1, all other outputs 0.
- States are IDLE, RUN, MEM_WAIT and HALTED. Encodings are registered; all outputs are decoded combinationally from the state and the inputs.
- IDLE: on start=1, go to RUN on the next edge.
- RUN: en=1. Hazard conditions are evaluated in priority order:
  1. Memory wait: MM_req && !MM_ack asserts stall_fe=1 and stall_be=1 in the same cycle, and the state goes to MEM_WAIT. Load-use and jump are ignored this cycle; EX is frozen, so EX_jump is re-evaluated later.
  2. Jump: EX_jump=1 asserts kill_fe=1 this cycle and loads the shadow counter with IMEM_LAT. kill_fe then stays 1 while the counter is nonzero; the counter decrements each non-stalled cycle. A new EX_jump reloads the counter.
  3. Load-use: the condition is EX_is_load && EX_reg_wr && EX_reg_addr_rd!=0 && ((ID_uses_r1 && rd==rs1) || (ID_uses_r2 && rd==rs2)). When the condition holds and kill_fe=0: stall_fe=1 and bubble_ex=1 for exactly one cycle. The condition is suppressed while kill_fe=1, because the ID instruction is wrong-path.
  4. Halt: halt_req && !kill_fe && !stall_fe goes to HALTED on the next edge.
- MEM_WAIT: en=1, stall_fe=1, stall_be=1, and the shadow counter is frozen.
  - In the cycle MM_ack=1, the stalls deassert combinationally and the state returns to RUN.
  - A jump sitting in EX is honoured in that same cycle.
- HALTED: en=0, halted=1, kill_fe=0, and the perf counters hold. start=1 goes to RUN.
- Counters:
  - cyc_cnt increments on each cycle with en=1.
  - stall_cnt increments on each cycle with stall_fe=1.
  - Both wrap modulo 2^CNT_W with no saturation.
  - Counters are not cleared by start.
- start in RUN or MEM_WAIT is ignored. halt_req in MEM_WAIT is ignored; ID holds the instruction, so it is seen again after the wait.

Decomposition:
- defines.vh gains the state encodings PCTRL_ST_IDLE, PCTRL_ST_RUN, PCTRL_ST_MEMW and PCTRL_ST_HALT, plus PCTRL_CNT_W.
- One combinational sub-module, hazard_detect, contains the load-use comparator. It is reused later by the MM-stage forwarding check.

Test Plan:
- Reset, then a 1-cycle start pulse: en=0 and kill_fe=1 while in IDLE; en=1 one cycle after start; cyc_cnt=3 after 3 RUN cycles.
- EX_is_load=1, EX_reg_wr=1, EX_reg_addr_rd=5, ID_reg_addr_r1=5, ID_uses_r1=1: stall_fe=1 and bubble_ex=1 for exactly 1 cycle, and stall_cnt increments by 1. Repeating with rd=0, or with ID_uses_r1=0: no stall.
- EX_jump high for 1 cycle with IMEM_LAT=1: kill_fe high for 2 cycles. A load-use match during those cycles gives bubble_ex=0.
- MM_req=1 with MM_ack=0 for 3 cycles, then 1: stall_fe and stall_be high for 3 cycles, low in the ack cycle; stall_cnt increases by 3. With EX_jump=1 held throughout, kill_fe first rises in the ack cycle.
- halt_req=1 in RUN: halted=1 and en=0 from the next cycle; counters hold; a later start returns to RUN with counters continuing from their held values.
- rst_n driven low mid-MEM_WAIT, asynchronously to clk: en=0, stalls=0, kill_fe=1 and counters=0 without waiting for a clock edge.
